// File: rtl/w_dff_bank_ctrl_if.sv
// Command and flip-flop-bank bus between a command source and w_dff_bank_ctrl.
// The master drives commands and Q feedback; the slave (controller) drives the bank strobes.
interface w_dff_bank_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [3:0] cmd_sel;
   logic [3:0] cmd_data;
   logic [3:0] ff_s;
   logic [3:0] ff_r;
   logic [3:0] ff_d;
   logic [3:0] ff_ce;
   logic [3:0] q_in;
   logic       done;
   logic       err;

   modport master (
      output cmd_valid, cmd_op, cmd_sel, cmd_data, q_in,
      input  cmd_ready, ff_s, ff_r, ff_d, ff_ce, done, err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_sel, cmd_data, q_in,
      output cmd_ready, ff_s, ff_r, ff_d, ff_ce, done, err
   );
endinterface

// File: rtl/w_dff_bank_ctrl.sv
// Sequencer for a 4-bit D flip-flop bank: async set/clear strobes, parallel load, serial shift.
// Define W_DFF_BANK_CTRL_VERIFY_EN to add the post-LOAD read-back CHECK state.
module w_dff_bank_ctrl #(
   parameter int PULSE_W = 2,
   parameter int RECOV_W = 1
) (
   input logic              CLK,
   input logic              R,
   w_dff_bank_ctrl_if.slave bus
);

   generate
      if (PULSE_W < 1 || PULSE_W > 15) begin : g_bad_pulse
         $error("PULSE_W out of range 1..15");
      end
      if (RECOV_W < 1 || RECOV_W > 7) begin : g_bad_recov
         $error("RECOV_W out of range 1..7");
      end
   endgenerate

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_SET   = 3'b001;
   localparam logic [2:0] OP_CLEAR = 3'b010;
   localparam logic [2:0] OP_LOAD  = 3'b011;
   localparam logic [2:0] OP_SHIFT = 3'b100;

   localparam logic [3:0] PULSE_LAST = 4'(PULSE_W - 1);
   localparam logic [3:0] RECOV_LAST = 4'(RECOV_W - 1);
   localparam logic [3:0] SHIFT_LAST = 4'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_STROBE, S_RECOV, S_LOAD, S_CHECK, S_SHIFT, S_DONE
   } state_t;

   state_t     r_state, w_next;
   logic [3:0] r_cnt, w_cnt_nxt;
   logic [2:0] r_op;
   logic [3:0] r_sel, r_data, r_ff_d;
   logic       r_err, r_armed;

   logic       w_ready, w_accept, w_illegal, w_chk_fail;
   logic [3:0] w_ff_s, w_ff_r, w_ff_d, w_ff_ce;
   logic       w_done;

   // r_armed holds cmd_ready low until the first edge after reset release.
   assign w_ready   = (r_state == S_IDLE) && r_armed;
   assign w_accept  = bus.cmd_valid && w_ready;
   assign w_illegal = (bus.cmd_op > OP_SHIFT);

`ifdef W_DFF_BANK_CTRL_VERIFY_EN
   assign w_chk_fail = (r_state == S_CHECK) && (bus.q_in != r_data);
`else
   logic w_unused_q3;
   assign w_chk_fail  = 1'b0;
   assign w_unused_q3 = bus.q_in[3];
`endif

   always_ff @(posedge CLK or negedge R) begin
      if (!R) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_op    <= OP_NOP;
         r_sel   <= '0;
         r_data  <= '0;
         r_ff_d  <= '0;
         r_err   <= 1'b0;
         r_armed <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
         r_ff_d  <= w_ff_d;
         r_armed <= 1'b1;
         if (w_accept) begin
            r_op   <= bus.cmd_op;
            r_sel  <= bus.cmd_sel;
            r_data <= bus.cmd_data;
         end
         if ((w_accept && w_illegal) || w_chk_fail)
            r_err <= 1'b1;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_cnt_nxt = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_cnt_nxt = '0;
               case (bus.cmd_op)
                  OP_NOP:   w_next = S_DONE;
                  // An empty mask has nothing to strobe, so no recovery is owed.
                  OP_SET,
                  OP_CLEAR: w_next = (bus.cmd_sel == 4'b0000) ? S_DONE : S_STROBE;
                  OP_LOAD:  w_next = S_LOAD;
                  OP_SHIFT: w_next = S_SHIFT;
                  default:  w_next = S_DONE;
               endcase
            end
         end
         S_STROBE: begin
            if (r_cnt == PULSE_LAST) begin
               w_next    = S_RECOV;
               w_cnt_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         S_RECOV: begin
            if (r_cnt == RECOV_LAST) begin
               w_next    = S_DONE;
               w_cnt_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         S_LOAD: begin
`ifdef W_DFF_BANK_CTRL_VERIFY_EN
            w_next = S_CHECK;
`else
            w_next = S_DONE;
`endif
         end
         S_CHECK: w_next = S_DONE;
         S_SHIFT: begin
            if (r_cnt == SHIFT_LAST) begin
               w_next    = S_DONE;
               w_cnt_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs decode from the async-reset state, so R low releases strobes at once.
   always_comb begin
      w_ff_s  = 4'b1111;
      w_ff_r  = 4'b1111;
      w_ff_ce = 4'b0000;
      w_ff_d  = r_ff_d;
      w_done  = 1'b0;
      case (r_state)
         S_STROBE: begin
            if (r_op == OP_SET) w_ff_s = ~r_sel;
            else                w_ff_r = ~r_sel;
         end
         S_LOAD: begin
            w_ff_ce = 4'b1111;
            w_ff_d  = r_data;
         end
         S_SHIFT: begin
            w_ff_ce = 4'b1111;
            w_ff_d  = {bus.q_in[2:0], r_data[0]};
         end
         S_DONE:  w_done = 1'b1;
         default: ;
      endcase
   end

   assign bus.cmd_ready = w_ready;
   assign bus.ff_s      = w_ff_s;
   assign bus.ff_r      = w_ff_r;
   assign bus.ff_d      = w_ff_d;
   assign bus.ff_ce     = w_ff_ce;
   assign bus.done      = w_done;
   assign bus.err       = r_err;

endmodule

// File: tb/tb_w_dff_bank_ctrl.sv
// Directed bench for w_dff_bank_ctrl (PULSE_W=2, RECOV_W=1); follows W_DFF_BANK_CTRL_VERIFY_EN if defined.
module tb_w_dff_bank_ctrl;
   logic CLK = 1'b0;
   logic R;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 CLK = ~CLK;

   w_dff_bank_ctrl_if bus ();

   w_dff_bank_ctrl #(.PULSE_W(2), .RECOV_W(1)) dut (
      .CLK (CLK),
      .R   (R),
      .bus (bus.slave)
   );

   task automatic send(input logic [2:0] op, input logic [3:0] sel, input logic [3:0] data);
      @(negedge CLK);
      n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL cmd_ready_pre got=%b exp=1", bus.cmd_ready); end
      bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_sel = sel; bus.cmd_data = data;
      @(posedge CLK);
      #1 bus.cmd_valid = 1'b0; bus.cmd_op = 3'b000; bus.cmd_sel = 4'b0000; bus.cmd_data = 4'b0000;
   endtask

   task automatic test_reset;
      R = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_op = 3'b000; bus.cmd_sel = 4'b0000; bus.cmd_data = 4'b0000; bus.q_in = 4'b0000;
      #12;
      n_cmp++; if (bus.ff_s !== 4'b1111) begin n_err++; $display("FAIL rst_ff_s got=%b exp=1111", bus.ff_s); end
      n_cmp++; if (bus.ff_r !== 4'b1111) begin n_err++; $display("FAIL rst_ff_r got=%b exp=1111", bus.ff_r); end
      n_cmp++; if (bus.ff_ce !== 4'b0000) begin n_err++; $display("FAIL rst_ff_ce got=%b exp=0000", bus.ff_ce); end
      n_cmp++; if (bus.ff_d !== 4'b0000) begin n_err++; $display("FAIL rst_ff_d got=%b exp=0000", bus.ff_d); end
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b exp=0", bus.done); end
      n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL rst_err got=%b exp=0", bus.err); end
      n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got=%b exp=0", bus.cmd_ready); end
      @(negedge CLK); R = 1'b1;
      #1;
      n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL rel_ready_early got=%b exp=0", bus.cmd_ready); end
      @(negedge CLK);
      n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready got=%b exp=1", bus.cmd_ready); end
   endtask

   task automatic test_set;
      send(3'b001, 4'b0101, 4'b0000);
      for (int c = 1; c <= 2; c++) begin
         @(negedge CLK);
         n_cmp++; if (bus.ff_s !== 4'b1010) begin n_err++; $display("FAIL set_strobe%0d ff_s got=%b exp=1010", c, bus.ff_s); end
         n_cmp++; if (bus.ff_r !== 4'b1111) begin n_err++; $display("FAIL set_strobe%0d ff_r got=%b exp=1111", c, bus.ff_r); end
         n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL set_busy%0d ready got=%b exp=0", c, bus.cmd_ready); end
      end
      @(negedge CLK);
      n_cmp++; if (bus.ff_s !== 4'b1111) begin n_err++; $display("FAIL set_recov ff_s got=%b exp=1111", bus.ff_s); end
      n_cmp++; if (bus.ff_ce !== 4'b0000) begin n_err++; $display("FAIL set_recov ff_ce got=%b exp=0000", bus.ff_ce); end
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL set_recov done got=%b exp=0", bus.done); end
      @(negedge CLK);
      n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL set_done got=%b exp=1", bus.done); end
      n_cmp++; if (bus.ff_r !== 4'b1111) begin n_err++; $display("FAIL set_done ff_r got=%b exp=1111", bus.ff_r); end
      @(negedge CLK);
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL set_done_pulse got=%b exp=0", bus.done); end
      n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL set_ready_back got=%b exp=1", bus.cmd_ready); end
   endtask

   task automatic test_sel_zero;
      send(3'b001, 4'b0000, 4'b0000);
      @(negedge CLK);
      n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL selzero_done got=%b exp=1", bus.done); end
      n_cmp++; if (bus.ff_s !== 4'b1111) begin n_err++; $display("FAIL selzero_ff_s got=%b exp=1111", bus.ff_s); end
   endtask

   task automatic test_load_ok;
      bus.q_in = 4'b1011;
      send(3'b011, 4'b0000, 4'b1011);
      @(negedge CLK);
      n_cmp++; if (bus.ff_ce !== 4'b1111) begin n_err++; $display("FAIL load_ce got=%b exp=1111", bus.ff_ce); end
      n_cmp++; if (bus.ff_d !== 4'b1011) begin n_err++; $display("FAIL load_d got=%b exp=1011", bus.ff_d); end
      @(negedge CLK);
      n_cmp++; if (bus.ff_ce !== 4'b0000) begin n_err++; $display("FAIL load_ce_off got=%b exp=0000", bus.ff_ce); end
      n_cmp++; if (bus.ff_d !== 4'b1011) begin n_err++; $display("FAIL load_d_hold got=%b exp=1011", bus.ff_d); end
`ifdef W_DFF_BANK_CTRL_VERIFY_EN
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL load_check_done got=%b exp=0", bus.done); end
      @(negedge CLK);
`endif
      n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL load_done got=%b exp=1", bus.done); end
      n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL load_ok_err got=%b exp=0", bus.err); end
   endtask

   task automatic test_load_bad;
      logic exp_err;
`ifdef W_DFF_BANK_CTRL_VERIFY_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      bus.q_in = 4'b0011;
      send(3'b011, 4'b0000, 4'b1011);
`ifdef W_DFF_BANK_CTRL_VERIFY_EN
      repeat (3) @(negedge CLK);
`else
      repeat (2) @(negedge CLK);
`endif
      n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL loadbad_done got=%b exp=1", bus.done); end
      n_cmp++; if (bus.err !== exp_err) begin n_err++; $display("FAIL loadbad_err got=%b exp=%b", bus.err, exp_err); end
      send(3'b000, 4'b0000, 4'b0000);
      @(negedge CLK);
      n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL nop_done got=%b exp=1", bus.done); end
      n_cmp++; if (bus.err !== exp_err) begin n_err++; $display("FAIL nop_err_sticky got=%b exp=%b", bus.err, exp_err); end
   endtask

   task automatic test_shift;
      bus.q_in = 4'b0000;
      send(3'b100, 4'b0000, 4'b0001);
      for (int c = 1; c <= 4; c++) begin
         @(negedge CLK);
         n_cmp++; if (bus.ff_d !== 4'b0001) begin n_err++; $display("FAIL shift%0d ff_d got=%b exp=0001", c, bus.ff_d); end
         n_cmp++; if (bus.ff_ce !== 4'b1111) begin n_err++; $display("FAIL shift%0d ff_ce got=%b exp=1111", c, bus.ff_ce); end
      end
      @(negedge CLK);
      n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL shift_done got=%b exp=1", bus.done); end
      n_cmp++; if (bus.ff_ce !== 4'b0000) begin n_err++; $display("FAIL shift_ce_off got=%b exp=0000", bus.ff_ce); end
   endtask

   task automatic test_illegal_clear;
      @(negedge CLK); R = 1'b0;
      @(negedge CLK); R = 1'b1;
      send(3'b111, 4'b1111, 4'b1111);
      @(negedge CLK);
      n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL ill_done got=%b exp=1", bus.done); end
      n_cmp++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL ill_err got=%b exp=1", bus.err); end
      n_cmp++; if ({bus.ff_s, bus.ff_r} !== 8'hFF) begin n_err++; $display("FAIL ill_strobes got=%b_%b exp=1111_1111", bus.ff_s, bus.ff_r); end
      n_cmp++; if (bus.ff_ce !== 4'b0000) begin n_err++; $display("FAIL ill_ce got=%b exp=0000", bus.ff_ce); end
      send(3'b010, 4'b1111, 4'b0000);
      for (int c = 1; c <= 2; c++) begin
         @(negedge CLK);
         n_cmp++; if (bus.ff_r !== 4'b0000) begin n_err++; $display("FAIL clr%0d ff_r got=%b exp=0000", c, bus.ff_r); end
         n_cmp++; if (bus.ff_s !== 4'b1111) begin n_err++; $display("FAIL clr%0d ff_s got=%b exp=1111", c, bus.ff_s); end
      end
      @(negedge CLK);
      n_cmp++; if (bus.ff_r !== 4'b1111) begin n_err++; $display("FAIL clr_recov ff_r got=%b exp=1111", bus.ff_r); end
      @(negedge CLK);
      n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL clr_done got=%b exp=1", bus.done); end
      n_cmp++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL clr_err_sticky got=%b exp=1", bus.err); end
   endtask

   task automatic test_reset_mid_set;
      send(3'b001, 4'b1111, 4'b0000);
      @(negedge CLK);
      n_cmp++; if (bus.ff_s !== 4'b0000) begin n_err++; $display("FAIL midrst_pre ff_s got=%b exp=0000", bus.ff_s); end
      #2 R = 1'b0;
      #1;
      n_cmp++; if (bus.ff_s !== 4'b1111) begin n_err++; $display("FAIL midrst ff_s got=%b exp=1111", bus.ff_s); end
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL midrst done got=%b exp=0", bus.done); end
      n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL midrst err got=%b exp=0", bus.err); end
      @(negedge CLK);
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL midrst_hold done got=%b exp=0", bus.done); end
      R = 1'b1;
      #1;
      n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready_early got=%b exp=0", bus.cmd_ready); end
      @(negedge CLK);
      n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready got=%b exp=1", bus.cmd_ready); end
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL midrst_no_done got=%b exp=0", bus.done); end
   endtask

   initial begin
      test_reset();
      test_set();
      test_sel_zero();
      test_load_ok();
      test_load_bad();
      test_shift();
      test_illegal_clear();
      test_reset_mid_set();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/w_dff_bank_ctrl.md
W_DFF_BANK_CTRL -- requirements
Module: w_dff_bank_ctrl

Interface
REQ-001 Parameter PULSE_W, default 2: low time in CLK cycles of async set/reset strobes; legal range 1..15.
REQ-002 Parameter RECOV_W, default 1: recovery cycles after strobe release before the next clock-enable; legal range 1..7.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 R  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  in  1  command present.
REQ-006 cmd_ready  out  1  controller accepts command this cycle.
REQ-007 cmd_op  in  3  000 NOP, 001 SET, 010 CLEAR, 011 LOAD, 100 SHIFT; others illegal.
REQ-008 cmd_sel  in  4  per-flip-flop select mask for SET/CLEAR.
REQ-009 cmd_data  in  4  LOAD value; bit 0 is SHIFT serial input.
REQ-010 ff_s  out  4  active-low async set strobes to the D flip-flop bank.
REQ-011 ff_r  out  4  active-low async reset strobes to the bank.
REQ-012 ff_d  out  4  D inputs to the bank.
REQ-013 ff_ce  out  4  per-flip-flop clock enables.
REQ-014 q_in  in  4  Q feedback from the bank.
REQ-015 done  out  1  one-cycle pulse on command completion.
REQ-016 err  out  1  sticky error flag.

Function
REQ-017 FSM states: IDLE, STROBE, RECOV, LOAD, CHECK, SHIFT, DONE.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid and cmd_ready are both 1 on a rising edge; op, sel, data are registered at acceptance.
REQ-019 NOP: IDLE -> DONE; done pulses the cycle after acceptance.
REQ-020 SET/CLEAR: IDLE -> STROBE; ff_s (SET) or ff_r (CLEAR) bits selected by cmd_sel driven 0 for exactly PULSE_W cycles, unselected bits held 1.
REQ-021 STROBE -> RECOV for RECOV_W cycles with all strobes 1 and ff_ce 0, then -> DONE.
REQ-022 SET or CLEAR with cmd_sel == 0 SHALL skip STROBE and RECOV, going directly to DONE.
REQ-023 ff_s and ff_r SHALL never both be 0 on the same bit in any cycle.
REQ-024 LOAD: IDLE -> LOAD for one cycle, ff_d = data and ff_ce = 1111; then -> CHECK, or -> DONE when checking is compiled out.
REQ-025 CHECK: one cycle; q_in compared with data; mismatch sets err; -> DONE.
REQ-026 SHIFT: 4 cycles, ff_ce = 1111 each; ff_d = {q_in[2:0], data[0]}; -> DONE.
REQ-027 DONE: done = 1 for one cycle; -> IDLE; cmd_ready returns to 1 the following cycle.
REQ-028 Illegal op: accepted, sets err, -> DONE with no strobe, load or enable activity.
REQ-029 err SHALL stay 1 until reset; it never blocks further commands.
REQ-030 ff_ce SHALL be 0 in every state other than LOAD and SHIFT; ff_d SHALL hold its last value elsewhere.
REQ-031 cmd_valid while busy is ignored; there is no queueing.

Reset
REQ-032 R low SHALL immediately force state IDLE, ff_s = ff_r = 1111, ff_ce = 0000, ff_d = 0000, done = 0, err = 0, cmd_ready = 0.
REQ-033 R low during STROBE SHALL release the strobes asynchronously, with no completion pulse.
REQ-034 cmd_ready SHALL rise on the first CLK edge after R deasserts.

Configuration
REQ-035 Macro W_DFF_BANK_CTRL_VERIFY_EN defined: the CHECK state and LOAD read-back comparison are present.
REQ-036 Macro W_DFF_BANK_CTRL_VERIFY_EN undefined: LOAD -> DONE directly, and err is driven only by illegal ops; LOAD latency is 1 cycle shorter.

Verification
REQ-037 Reset R low mid-SET, with PULSE_W = 2, RECOV_W = 1 -> ff_s returns to 1111 in the same cycle, no done, and cmd_ready = 1 one edge after R rises.
REQ-038 SET, cmd_sel = 0101 -> ff_s = 1010 for 2 cycles, then 1 recovery cycle, then done; ff_r stays 1111 throughout.
REQ-039 LOAD data = 1011 with q_in = 1011 -> ff_ce = 1111 for 1 cycle, done 2 cycles after the load cycle, err = 0.
REQ-040 LOAD data = 1011 with q_in = 0011 and the macro defined -> err = 1 and remains set across a subsequent NOP.
REQ-041 SHIFT with data[0] = 1 and q_in held at 0000 -> ff_d = 0001 for 4 cycles, with ff_ce active 4 cycles, then done.
REQ-042 Illegal op 111, then CLEAR with cmd_sel = 1111 -> err = 1 with no strobes; CLEAR then drives ff_r = 0000 for 2 cycles.
